ex_forward_stage: RTL
=====================

EX_FORWARD_STAGE -- requirements
Module: ex_forward_stage

Interface
REQ-001 Parameter DATA_W, 32, operand/result width in bits.
REQ-002 Parameter REG_W, 5, register-address width.
REQ-003 Parameter CNT_W, 16, stall-counter width.
REQ-004 Parameter FWD_EN, 1: 1 = forwarding with load-use stall; 0 = no forwarding, stall on any pending write.
REQ-005 One clock and one reset: reset is synchronous and active-high; ports are named clk and reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  synchronous active-high reset.
REQ-008 flush  in  1  kill the instruction in ID/EX and abort any stall.
REQ-009 id_valid  in  1  ID/EX holds a valid instruction.
REQ-010 rs_addr, rt_addr  in  REG_W  source register addresses.
REQ-011 rs_data, rt_data  in  DATA_W  register-file read values.
REQ-012 exm_wr, exm_load  in  1  EX/MEM instruction writes a register / is a load.
REQ-013 exm_rd  in  REG_W; exm_result  in  DATA_W  EX/MEM destination and ALU result.
REQ-014 wb_wr  in  1; wb_rd  in  REG_W; wb_data  in  DATA_W  MEM/WB write port.
REQ-015 op_a, op_b  out  DATA_W  registered resolved operands.
REQ-016 sel_a, sel_b  out  2  registered source code: 00 reg file, 10 EX/MEM, 01 MEM/WB, 11 constant zero.
REQ-017 op_valid  out  1  registered; op_a/op_b are valid this cycle.
REQ-018 stall  out  1  freeze PC and IF/ID, hold ID/EX.
REQ-019 stall_count  out  CNT_W  saturating count of stall cycles.

Function
REQ-020 Match(x, addr) is defined as x_wr=1, x_rd!=0 and x_rd==addr.
REQ-021 Source-operand resolution order: addr==0 gives 11/zero; else EX/MEM match with exm_load=0 gives 10/exm_result; else MEM/WB match gives 01/wb_data; else 00/reg-file data.
REQ-022 With FWD_EN=0, sel is always 00 except 11 for addr 0, and the value is the reg-file data.
REQ-023 FSM states: RUN and HOLD, with a 2-bit down-counter hold_cnt.
REQ-024 RUN hazard, FWD_EN=1: id_valid and EX/MEM match on rs or rt with exm_load=1.
REQ-025 RUN hazard, FWD_EN=0: id_valid and an EX/MEM match on rs or rt gives length 2; otherwise a MEM/WB match only gives length 1.
REQ-026 In RUN, stall equals hazard combinationally, in the same cycle.
REQ-027 A hazard of length 1 in RUN stays in RUN.
REQ-028 A hazard of length 2 in RUN moves to HOLD with hold_cnt=1.
REQ-029 In HOLD, stall=1 and inputs are ignored; when hold_cnt reaches 0, return to RUN and re-evaluate the hazard in that cycle.
REQ-030 Output register update: flush or stall gives op_valid<=0 with op/sel held; else id_valid gives op/sel<=resolved values and op_valid<=1; else op_valid<=0.
REQ-031 Latency: one cycle from the non-stalled id_valid cycle to op_valid.
REQ-032 flush has priority over hazard: stall=0 in that cycle, state<=RUN, and hold_cnt<=0.
REQ-033 stall_count increments by 1 in each cycle with stall=1 and saturates at all-ones without wrapping.
REQ-034 Simultaneous EX/MEM and MEM/WB match on one register: EX/MEM wins, unless it is a load, in which case the load hazard applies.
REQ-035 rs_addr==rt_addr resolves identically for both operands and counts as a single hazard.

Reset
REQ-036 Reset state is RUN, with hold_cnt=0, op_a=op_b=0, sel_a=sel_b=00, op_valid=0 and stall_count=0.
REQ-037 stall is 0 during any cycle in which reset=1.
REQ-038 Reset asserted in HOLD returns the FSM to RUN on the next edge and discards the stall.

Verification
REQ-039 FWD_EN=1; rs=3, exm_wr=1, exm_rd=3, exm_result=0x11, exm_load=0 -> next cycle op_a=0x11, sel_a=10, op_valid=1, stall=0.
REQ-040 FWD_EN=1; rt=7, exm_load=1, exm_rd=7 -> stall=1 for one cycle, op_valid=0; next cycle with wb_rd=7, wb_data=0xAB -> op_b=0xAB, sel_b=01, stall_count=1.
REQ-041 rs=0 with exm_rd=0, exm_wr=1 -> op_a=0, sel_a=11, no stall.
REQ-042 FWD_EN=0; rs=4, exm_rd=4, exm_wr=1 -> stall high for exactly 2 cycles, then op_a=rs_data, sel_a=00, stall_count=2.
REQ-043 FWD_EN=0 in HOLD; flush=1 -> stall=0 that cycle, op_valid=0, FSM in RUN next cycle.
REQ-044 With CNT_W=2, 5 stall cycles -> stall_count=3 (saturated), and reset mid-stall -> stall_count=0 and stall=0 next cycle.

Source files
------------

// File: rtl/ex_forward_stage.sv
// ex_forward_stage: EX operand forwarding with hazard-driven stall control.
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   flush                   kill the ID/EX instruction and abort any stall
//   id_valid                ID/EX holds a valid instruction
//   rs_addr/rt_addr         source register addresses
//   rs_data/rt_data         register-file read values
//   exm_wr/exm_load         EX/MEM writes a register / is a load
//   exm_rd/exm_result       EX/MEM destination and ALU result
//   wb_wr/wb_rd/wb_data     MEM/WB write port
//   op_a/op_b, sel_a/sel_b  registered operands and source codes
//                           (00 reg file, 10 EX/MEM, 01 MEM/WB, 11 zero)
//   op_valid                registered operand-valid flag
//   stall                   freeze PC and IF/ID, hold ID/EX
//   stall_count             saturating count of stall cycles
module ex_forward_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int CNT_W  = 16,
   parameter int FWD_EN = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  rs_addr,
   input  logic [REG_W-1:0]  rt_addr,
   input  logic [DATA_W-1:0] rs_data,
   input  logic [DATA_W-1:0] rt_data,
   input  logic              exm_wr,
   input  logic              exm_load,
   input  logic [REG_W-1:0]  exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_wr,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] op_a,
   output logic [DATA_W-1:0] op_b,
   output logic [1:0]        sel_a,
   output logic [1:0]        sel_b,
   output logic              op_valid,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_count
);
   typedef enum logic {RUN, HOLD} state_t;
   state_t            r_state, w_next;
   logic [1:0]        r_hold_cnt, w_hold_nxt;
   logic [DATA_W-1:0] r_op_a, r_op_b;
   logic [1:0]        r_sel_a, r_sel_b;
   logic              r_op_valid;
   logic [CNT_W-1:0]  r_stall_count;
   logic              w_ex_a, w_ex_b, w_wb_a, w_wb_b;
   logic              w_haz1, w_haz2;
   logic [1:0]        w_sel_a, w_sel_b;
   logic [DATA_W-1:0] w_op_a, w_op_b;

   assign w_ex_a = exm_wr && exm_rd != '0 && exm_rd == rs_addr;
   assign w_ex_b = exm_wr && exm_rd != '0 && exm_rd == rt_addr;
   assign w_wb_a = wb_wr && wb_rd != '0 && wb_rd == rs_addr;
   assign w_wb_b = wb_wr && wb_rd != '0 && wb_rd == rt_addr;

   // Without forwarding, a producer still in EX/MEM needs two bubbles and one
   // in MEM/WB needs a single bubble; with forwarding only a load costs one.
   assign w_haz2 = (FWD_EN == 0) && id_valid && (w_ex_a || w_ex_b);
   assign w_haz1 = id_valid && ((FWD_EN != 0) ? exm_load && (w_ex_a || w_ex_b)
                                              : (w_wb_a || w_wb_b));

   assign w_sel_a = (rs_addr == '0) ? 2'b11 :
                    ((FWD_EN != 0) && w_ex_a && !exm_load) ? 2'b10 :
                    ((FWD_EN != 0) && w_wb_a) ? 2'b01 : 2'b00;
   assign w_sel_b = (rt_addr == '0) ? 2'b11 :
                    ((FWD_EN != 0) && w_ex_b && !exm_load) ? 2'b10 :
                    ((FWD_EN != 0) && w_wb_b) ? 2'b01 : 2'b00;
   assign w_op_a = (w_sel_a == 2'b10) ? exm_result : (w_sel_a == 2'b01) ? wb_data :
                   (w_sel_a == 2'b11) ? '0 : rs_data;
   assign w_op_b = (w_sel_b == 2'b10) ? exm_result : (w_sel_b == 2'b01) ? wb_data :
                   (w_sel_b == 2'b11) ? '0 : rt_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= RUN;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   // HOLD exits on the edge where hold_cnt decrements to zero, so the RUN
   // cycle that follows re-evaluates the hazard against fresh inputs.
   always_comb begin
      w_next     = r_state;
      w_hold_nxt = r_hold_cnt;
      if (flush) begin
         w_next     = RUN;
         w_hold_nxt = '0;
      end else if (r_state == HOLD) begin
         w_hold_nxt = (r_hold_cnt == '0) ? 2'd0 : r_hold_cnt - 2'd1;
         w_next     = (r_hold_cnt <= 2'd1) ? RUN : HOLD;
      end else if (w_haz2) begin
         w_next     = HOLD;
         w_hold_nxt = 2'd1;
      end
   end

   always_comb begin
      stall = !reset && !flush && (r_state == HOLD || w_haz1 || w_haz2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_a     <= '0;
         r_op_b     <= '0;
         r_sel_a    <= 2'b00;
         r_sel_b    <= 2'b00;
         r_op_valid <= 1'b0;
      end else if (flush || stall) begin
         r_op_valid <= 1'b0;
      end else if (id_valid) begin
         r_op_a     <= w_op_a;
         r_op_b     <= w_op_b;
         r_sel_a    <= w_sel_a;
         r_sel_b    <= w_sel_b;
         r_op_valid <= 1'b1;
      end else begin
         r_op_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_stall_count <= '0;
      else if (stall && !(&r_stall_count)) r_stall_count <= r_stall_count + CNT_W'(1);
   end

   assign op_a        = r_op_a;
   assign op_b        = r_op_b;
   assign sel_a       = r_sel_a;
   assign sel_b       = r_sel_b;
   assign op_valid    = r_op_valid;
   assign stall_count = r_stall_count;
endmodule
